// File: rtl/seg_reader_pkg.sv
// Shared definitions for the seven-segment reader: active-low glyph table,
// blank pattern, reader states and the glyph-to-digit lookup.
package seg_reader_pkg;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    // Active-low {g,f,e,d,c,b,a} patterns for hex digits 0..F.
    localparam logic [6:0] GLYPHS [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0011000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    typedef enum logic {ACQUIRE, LOCKED} state_t;

    typedef struct packed {
        logic       hit;
        logic [3:0] value;
    } glyph_t;

    function automatic glyph_t decode_glyph(input logic [6:0] seg);
        glyph_t result;
        result = '0;
        for (int i = 0; i < 16; i++) begin
            if (seg == GLYPHS[i]) begin
                result.hit   = 1'b1;
                result.value = 4'(i);
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/seg_tick_gen.sv
// Reloading 28-bit down-counter; tick is high in the cycle the count is zero.
module seg_tick_gen #(
    parameter logic [27:0] TICK_DIV = 28'd50000
) (
    input  logic clk,
    input  logic reset,
    output logic tick
);

    logic [27:0] count;

    assign tick = (count == 28'd0);

    // NOTE: sequential state is assigned with non-blocking (<=) so every
    // register samples the values from before this edge.
    always_ff @(posedge clk) begin
        if (reset || tick)
            count <= TICK_DIV - 28'd1;
        else
            count <= count - 28'd1;
    end

endmodule

// File: rtl/seg_reader.sv
// Samples an active-low hex segment pattern on divided ticks, locks once it is
// stable, and reports the decoded digit or a blank/illegal pattern.
module seg_reader
    import seg_reader_pkg::*;
#(
    parameter logic [27:0] TICK_DIV     = 28'd50000,
    parameter int unsigned STABLE_COUNT = 4
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic [6:0] seg_in,
    input  logic       freeze,
    output logic [3:0] digit,
    output logic       digit_valid,
    output logic       blank,
    output logic       pattern_error,
    output logic       new_digit,
    output logic [7:0] change_count
);

    localparam logic [3:0] STABLE_LIMIT = 4'(STABLE_COUNT);

    logic       tick;
    state_t     state, state_next;
    logic [6:0] candidate, candidate_next;
    logic [3:0] stable_cnt, stable_next;
    logic [3:0] digit_next;
    logic       valid_next, blank_next, error_next, new_next;
    logic [7:0] count_next;
    glyph_t     glyph;

    seg_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
        .clk   (CLOCK_50),
        .reset (reset),
        .tick  (tick)
    );

    always_comb begin
        // NOTE: every signal written here gets its hold value first, so no
        // path through the branches below can infer a latch.
        state_next     = state;
        candidate_next = candidate;
        stable_next    = stable_cnt;
        digit_next     = digit;
        valid_next     = digit_valid;
        blank_next     = blank;
        error_next     = pattern_error;
        new_next       = 1'b0;
        count_next     = change_count;
        glyph          = decode_glyph(seg_in);

        if (tick && !freeze) begin
            candidate_next = seg_in;
            if (seg_in != candidate)
                stable_next = 4'd1;
            else if (stable_cnt < STABLE_LIMIT)
                stable_next = stable_cnt + 4'd1;

            unique case (state)
                ACQUIRE: begin
                    if (stable_next == STABLE_LIMIT) begin
                        state_next = LOCKED;
                        if (glyph.hit) begin
                            digit_next = glyph.value;
                            valid_next = 1'b1;
                            blank_next = 1'b0;
                            error_next = 1'b0;
                            // A re-lock after a glitch counts because valid was cleared.
                            if (!digit_valid || glyph.value != digit) begin
                                new_next   = 1'b1;
                                count_next = change_count + 8'd1;
                            end
                        end else if (seg_in == SEG_BLANK) begin
                            blank_next = 1'b1;
                            valid_next = 1'b0;
                            error_next = 1'b0;
                        end else begin
                            error_next = 1'b1;
                            valid_next = 1'b0;
                            blank_next = 1'b0;
                        end
                    end
                end
                LOCKED: begin
                    if (seg_in != candidate) begin
                        state_next = ACQUIRE;
                        valid_next = 1'b0;
                        blank_next = 1'b0;
                        error_next = 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state         <= ACQUIRE;
            candidate     <= SEG_BLANK;
            stable_cnt    <= 4'd0;
            digit         <= 4'd0;
            digit_valid   <= 1'b0;
            blank         <= 1'b0;
            pattern_error <= 1'b0;
            new_digit     <= 1'b0;
            change_count  <= 8'd0;
        end else begin
            state         <= state_next;
            candidate     <= candidate_next;
            stable_cnt    <= stable_next;
            digit         <= digit_next;
            digit_valid   <= valid_next;
            blank         <= blank_next;
            pattern_error <= error_next;
            new_digit     <= new_next;
            change_count  <= count_next;
        end
    end

endmodule

// File: tb/tb_seg_reader.sv
// Bench for seg_reader: two instances (fast and divided ticks) driven by the
// same stimulus, compared against a run-length reference model and an event scoreboard.
module tb_seg_reader;

    logic       CLOCK_50;
    logic       reset;
    logic [6:0] seg_in;
    logic       freeze;

    logic [3:0] digit_o [2];
    logic       valid_o [2];
    logic       blank_o [2];
    logic       error_o [2];
    logic       new_o   [2];
    logic [7:0] cc_o    [2];

    seg_reader #(.TICK_DIV(28'd1), .STABLE_COUNT(3)) dut_a (
        .CLOCK_50      (CLOCK_50),
        .reset         (reset),
        .seg_in        (seg_in),
        .freeze        (freeze),
        .digit         (digit_o[0]),
        .digit_valid   (valid_o[0]),
        .blank         (blank_o[0]),
        .pattern_error (error_o[0]),
        .new_digit     (new_o[0]),
        .change_count  (cc_o[0])
    );

    seg_reader #(.TICK_DIV(28'd4), .STABLE_COUNT(2)) dut_b (
        .CLOCK_50      (CLOCK_50),
        .reset         (reset),
        .seg_in        (seg_in),
        .freeze        (freeze),
        .digit         (digit_o[1]),
        .digit_valid   (valid_o[1]),
        .blank         (blank_o[1]),
        .pattern_error (error_o[1]),
        .new_digit     (new_o[1]),
        .change_count  (cc_o[1])
    );

    initial CLOCK_50 = 1'b0;
    always #5 CLOCK_50 = ~CLOCK_50;

    logic [6:0] tb_glyphs [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0011000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    int div_of [2] = '{1, 4};
    int st_of  [2] = '{3, 2};

    // Reference model: cycles since reset, sample run length, lock flag, outputs.
    int         m_cyc    [2];
    logic [6:0] m_last   [2];
    int         m_run    [2];
    bit         m_locked [2];
    int         m_digit  [2];
    bit         m_valid  [2];
    bit         m_blank  [2];
    bit         m_err    [2];
    bit         m_new    [2];
    int         m_cc     [2];

    typedef struct {
        int inst;
        int digit;
        int cc;
    } ev_t;
    ev_t sb[$];
    ev_t ev;

    int total_cnt = 0;
    int bad_cnt   = 0;
    bit mon_en    = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        total_cnt++;
        if (act != exp) begin
            bad_cnt++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Returns 0..15 for a glyph, 16 for blank, 17 for an illegal pattern.
    function automatic int classify(input logic [6:0] s);
        for (int k = 0; k < 16; k++)
            if (s == tb_glyphs[k]) return k;
        if (s == 7'h7f) return 16;
        return 17;
    endfunction

    task automatic model_step(input int i, input logic [6:0] s, input bit frz, input bit rst);
        bit tick_now;
        bit same;
        int cls;
        m_new[i] = 1'b0;
        if (rst) begin
            m_cyc[i] = 0; m_last[i] = 7'h7f; m_run[i] = 0; m_locked[i] = 1'b0;
            m_digit[i] = 0; m_valid[i] = 1'b0; m_blank[i] = 1'b0; m_err[i] = 1'b0; m_cc[i] = 0;
            return;
        end
        tick_now = (m_cyc[i] % div_of[i]) == div_of[i] - 1;
        m_cyc[i]++;
        if (!tick_now || frz) return;
        same      = (s == m_last[i]);
        m_run[i]  = same ? ((m_run[i] < st_of[i]) ? m_run[i] + 1 : st_of[i]) : 1;
        m_last[i] = s;
        if (m_locked[i]) begin
            if (!same) begin
                m_locked[i] = 1'b0;
                m_valid[i] = 1'b0; m_blank[i] = 1'b0; m_err[i] = 1'b0;
            end
        end else if (m_run[i] == st_of[i]) begin
            m_locked[i] = 1'b1;
            cls = classify(s);
            if (cls < 16) begin
                if (!m_valid[i] || m_digit[i] != cls) begin
                    m_new[i] = 1'b1;
                    m_cc[i]  = (m_cc[i] + 1) % 256;
                    sb.push_back('{inst: i, digit: cls, cc: m_cc[i]});
                end
                m_digit[i] = cls; m_valid[i] = 1'b1; m_blank[i] = 1'b0; m_err[i] = 1'b0;
            end else begin
                m_valid[i] = 1'b0;
                m_blank[i] = (cls == 16);
                m_err[i]   = (cls == 17);
            end
        end
    endtask

    task automatic cyc(input logic [6:0] s, input bit frz, input bit rst);
        @(negedge CLOCK_50);
        seg_in = s; freeze = frz; reset = rst;
        @(posedge CLOCK_50);
        model_step(0, s, frz, rst);
        model_step(1, s, frz, rst);
        mon_en = 1'b1;
    endtask

    task automatic drive(input logic [6:0] s, input bit frz, input int n);
        repeat (n) cyc(s, frz, 1'b0);
    endtask

    task automatic do_reset();
        cyc(seg_in, 1'b0, 1'b1);
    endtask

    // Monitor: pops the scoreboard on every new_digit and tracks status outputs each cycle.
    always @(negedge CLOCK_50) begin
        if (mon_en) begin
            for (int i = 0; i < 2; i++) begin
                if (new_o[i] === 1'b1) begin
                    if (sb.size() == 0) begin
                        total_cnt++;
                        bad_cnt++;
                        $display("FAIL sb_pop[%0d]: got new_digit with digit %0d, expected no event", i, digit_o[i]);
                    end else begin
                        ev = sb.pop_front();
                        check($sformatf("ev_inst[%0d]", i), i, ev.inst);
                        check($sformatf("ev_digit[%0d]", i), int'(digit_o[i]), ev.digit);
                        check($sformatf("ev_count[%0d]", i), int'(cc_o[i]), ev.cc);
                    end
                end
                check($sformatf("new_digit[%0d]", i), int'(new_o[i]), int'(m_new[i]));
                check($sformatf("digit[%0d]", i), int'(digit_o[i]), m_digit[i]);
                check($sformatf("digit_valid[%0d]", i), int'(valid_o[i]), int'(m_valid[i]));
                check($sformatf("blank[%0d]", i), int'(blank_o[i]), int'(m_blank[i]));
                check($sformatf("pattern_error[%0d]", i), int'(error_o[i]), int'(m_err[i]));
                check($sformatf("change_count[%0d]", i), int'(cc_o[i]), m_cc[i]);
            end
        end
    end

    initial begin
        logic [6:0] pat;
        int         kind;
        seg_in = 7'h7f; freeze = 1'b0; reset = 1'b1;

        // Lock on 2: the third sample lands on the third cycle after reset.
        do_reset();
        drive(7'b0100100, 1'b0, 3);
        #1;
        check("a_first_new_digit", int'(new_o[0]), 1);
        check("a_first_digit", int'(digit_o[0]), 2);
        drive(7'b0100100, 1'b0, 5);
        #1;
        check("a_first_count", int'(cc_o[0]), 1);
        check("a_first_valid", int'(valid_o[0]), 1);

        // Walk all sixteen glyphs from a fresh reset.
        do_reset();
        for (int v = 0; v < 16; v++) drive(tb_glyphs[v], 1'b0, 5);
        #1;
        check("a_walk_digit", int'(digit_o[0]), 15);
        check("a_walk_count", int'(cc_o[0]), 16);

        // Glitch on a locked 5, then blank and an illegal pattern.
        drive(7'b0010010, 1'b0, 6);
        drive(7'b0000000, 1'b0, 1);
        drive(7'b0010010, 1'b0, 6);
        #1;
        check("a_glitch_digit", int'(digit_o[0]), 5);
        drive(7'b1111111, 1'b0, 10);
        #1;
        check("a_blank", int'(blank_o[0]), 1);
        drive(7'b1010101, 1'b0, 10);
        #1;
        check("a_error", int'(error_o[0]), 1);
        check("a_error_digit_hold", int'(digit_o[0]), 5);

        // Divided ticks: lock visible right after the second tick (cycles 3 and 7).
        do_reset();
        drive(7'b1111001, 1'b0, 7);
        #1;
        check("b_not_yet_valid", int'(valid_o[1]), 0);
        drive(7'b1111001, 1'b0, 1);
        #1;
        check("b_lock_valid", int'(valid_o[1]), 1);
        check("b_lock_digit", int'(digit_o[1]), 1);
        drive(7'b1111001, 1'b0, 4);
        drive(7'b1111000, 1'b1, 12);
        #1;
        check("b_frozen_digit", int'(digit_o[1]), 1);
        check("a_frozen_digit", int'(digit_o[0]), 1);
        drive(7'b1111000, 1'b0, 12);
        #1;
        check("b_thawed_digit", int'(digit_o[1]), 7);

        // 256 alternating 3/4 locks wrap the change counter.
        do_reset();
        for (int n = 0; n < 256; n++) drive((n % 2 == 0) ? 7'b0110000 : 7'b0011001, 1'b0, 4);
        #1;
        check("a_wrap_count", int'(cc_o[0]), 0);
        check("a_wrap_digit", int'(digit_o[0]), 4);

        // Reset mid-acquire clears outputs and discards the partial count.
        drive(7'b0010010, 1'b0, 2);
        do_reset();
        #1;
        check("a_reset_valid", int'(valid_o[0]), 0);
        check("a_reset_digit", int'(digit_o[0]), 0);
        check("a_reset_count", int'(cc_o[0]), 0);
        drive(7'b0010010, 1'b0, 2);
        #1;
        check("a_partial_discarded", int'(valid_o[0]), 0);

        // Randomised segments: glyphs, blank, junk, glitches and occasional freeze.
        for (int n = 0; n < 300; n++) begin
            kind = int'($urandom_range(0, 9));
            if (kind <= 6)      pat = tb_glyphs[$urandom_range(0, 15)];
            else if (kind == 7) pat = 7'h7f;
            else                pat = 7'($urandom_range(0, 127));
            if (kind == 9)
                drive(pat, 1'b0, 1);
            else
                drive(pat, ($urandom_range(0, 9) == 0), int'($urandom_range(1, 12)));
            if (n == 150) do_reset();
        end

        @(negedge CLOCK_50);
        #1;
        check("sb_drained", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end

endmodule
